// File: rtl/pe_grid_sequencer_if.sv
// Signal bundle between pe_grid_sequencer and its host, shared memory and PE grid.
// The sequencer connects through the slave modport; the host side uses master.
interface pe_grid_sequencer_if #(
    parameter int GRID_COLS = 14,
    parameter int DATA_W    = 16
);
    logic                        start;
    logic [15:0]                 kernel_base;
    logic [15:0]                 image_base;
    logic [7:0]                  kernel_w;
    logic [7:0]                  kernel_h;
    logic [7:0]                  img_w;
    logic [7:0]                  img_h;
    logic [7:0]                  drain_cycles;
    logic                        hold;
    logic                        mem_rd_en;
    logic [15:0]                 mem_addr;
    logic [DATA_W-1:0]           mem_rd_data;
    logic [GRID_COLS*DATA_W-1:0] row_weight_vals;
    logic [3:0]                  tag_row;
    logic                        valid_y;
    logic [GRID_COLS*DATA_W-1:0] image_val_vec;
    logic [GRID_COLS-1:0]        valid_x_vec;
    logic                        busy;
    logic                        done;
    logic                        err;

    modport slave (
        input  start, kernel_base, image_base, kernel_w, kernel_h, img_w, img_h,
               drain_cycles, hold, mem_rd_data,
        output mem_rd_en, mem_addr, row_weight_vals, tag_row, valid_y,
               image_val_vec, valid_x_vec, busy, done, err
    );

    modport master (
        output start, kernel_base, image_base, kernel_w, kernel_h, img_w, img_h,
               drain_cycles, hold, mem_rd_data,
        input  mem_rd_en, mem_addr, row_weight_vals, tag_row, valid_y,
               image_val_vec, valid_x_vec, busy, done, err
    );
endinterface

// File: rtl/pe_grid_sequencer.sv
// Fetches kernel rows then image rows from memory and issues each row to the PE grid.
// Optional PE_SEQ_CFG_CHECK_EN: reject out-of-range dimensions with err instead of clamping.
module pe_grid_sequencer #(
    parameter int GRID_COLS = 14,
    parameter int GRID_ROWS = 12,
    parameter int DATA_W    = 16
) (
    input logic                clk,
    input logic                rst,
    pe_grid_sequencer_if.slave bus
);
    localparam logic [7:0] COLS8 = 8'(GRID_COLS);
    localparam logic [7:0] ROWS8 = 8'(GRID_ROWS);
    localparam int         VW    = GRID_COLS * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE, S_K_FETCH, S_K_ISSUE, S_I_FETCH, S_I_ISSUE, S_DRAIN, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       kbase_reg, ibase_reg;
    logic [7:0]        kw_reg, kh_reg, iw_reg, ih_reg, drain_reg;
    logic [7:0]        col_reg, row_reg, dcnt_reg;
    logic [VW-1:0]     weight_reg, image_reg;
    logic [3:0]        tag_reg;
    logic [VW-1:0]     row_buf;
    logic [GRID_COLS-1:0] vx_vec;

    logic [7:0]  kw_cfg, kh_cfg, iw_cfg, ih_cfg;
    logic        start_ok;

`ifdef PE_SEQ_CFG_CHECK_EN
    logic cfg_bad;
    logic err_reg;

    assign cfg_bad = (bus.kernel_w == 8'd0) || (bus.kernel_w > COLS8) ||
                     (bus.img_w == 8'd0)    || (bus.img_w > COLS8)    ||
                     (bus.kernel_h == 8'd0) || (bus.kernel_h > ROWS8) ||
                     (bus.img_h == 8'd0);
    assign kw_cfg   = bus.kernel_w;
    assign kh_cfg   = bus.kernel_h;
    assign iw_cfg   = bus.img_w;
    assign ih_cfg   = bus.img_h;
    assign start_ok = bus.start && !cfg_bad;

    // Every start seen in IDLE re-evaluates err, so a legal start clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_reg <= 1'b0;
        else if (state_reg == S_IDLE && bus.start)
            err_reg <= cfg_bad;
    end
    assign bus.err = err_reg;
`else
    function automatic logic [7:0] clamp_dim(input logic [7:0] v, input logic [7:0] hi);
        if (v == 8'd0)
            return 8'd1;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    assign kw_cfg   = clamp_dim(bus.kernel_w, COLS8);
    assign kh_cfg   = clamp_dim(bus.kernel_h, ROWS8);
    assign iw_cfg   = clamp_dim(bus.img_w, COLS8);
    assign ih_cfg   = (bus.img_h == 8'd0) ? 8'd1 : bus.img_h;
    assign start_ok = bus.start;
    assign bus.err  = 1'b0;
`endif

    logic        is_kernel, is_fetch, last_row;
    logic [7:0]  fetch_w;
    logic [15:0] fetch_base, row_off;

    assign is_kernel  = (state_reg == S_K_FETCH) || (state_reg == S_K_ISSUE);
    assign is_fetch   = (state_reg == S_K_FETCH) || (state_reg == S_I_FETCH);
    assign fetch_w    = is_kernel ? kw_reg : iw_reg;
    assign fetch_base = is_kernel ? kbase_reg : ibase_reg;
    assign row_off    = {8'd0, row_reg} * {8'd0, fetch_w};
    assign last_row   = (row_reg == ((is_kernel ? kh_reg : ih_reg) - 8'd1));

    logic        rd_en, vy, issue_x, busy_c, done_c;
    logic [15:0] addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        addr       = 16'd0;
        vy         = 1'b0;
        issue_x    = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                busy_c = 1'b0;
                if (start_ok)
                    state_next = S_K_FETCH;
            end
            S_K_FETCH, S_I_FETCH: begin
                // One spare cycle after the last read lets the final word land.
                if (col_reg < fetch_w) begin
                    rd_en = 1'b1;
                    addr  = fetch_base + row_off + {8'd0, col_reg};
                end else begin
                    state_next = (state_reg == S_K_FETCH) ? S_K_ISSUE : S_I_ISSUE;
                end
            end
            S_K_ISSUE: begin
                if (!bus.hold) begin
                    vy         = 1'b1;
                    state_next = last_row ? S_I_FETCH : S_K_FETCH;
                end
            end
            S_I_ISSUE: begin
                if (!bus.hold) begin
                    issue_x    = 1'b1;
                    state_next = !last_row ? S_I_FETCH :
                                 (drain_reg == 8'd0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dcnt_reg == drain_reg - 8'd1)
                    state_next = S_DONE;
            end
            S_DONE: begin
                done_c     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbase_reg  <= 16'd0;
            ibase_reg  <= 16'd0;
            kw_reg     <= 8'd0;
            kh_reg     <= 8'd0;
            iw_reg     <= 8'd0;
            ih_reg     <= 8'd0;
            drain_reg  <= 8'd0;
            col_reg    <= 8'd0;
            row_reg    <= 8'd0;
            dcnt_reg   <= 8'd0;
            weight_reg <= '0;
            image_reg  <= '0;
            tag_reg    <= 4'd0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        kbase_reg <= bus.kernel_base;
                        ibase_reg <= bus.image_base;
                        kw_reg    <= kw_cfg;
                        kh_reg    <= kh_cfg;
                        iw_reg    <= iw_cfg;
                        ih_reg    <= ih_cfg;
                        drain_reg <= bus.drain_cycles;
                        col_reg   <= 8'd0;
                        row_reg   <= 8'd0;
                        dcnt_reg  <= 8'd0;
                    end
                end
                S_K_FETCH, S_I_FETCH: begin
                    col_reg <= (col_reg < fetch_w) ? col_reg + 8'd1 : 8'd0;
                end
                S_K_ISSUE: begin
                    if (!bus.hold) begin
                        weight_reg <= row_buf;
                        tag_reg    <= row_reg[3:0];
                        row_reg    <= last_row ? 8'd0 : row_reg + 8'd1;
                    end
                end
                S_I_ISSUE: begin
                    if (!bus.hold) begin
                        image_reg <= row_buf;
                        row_reg   <= last_row ? 8'd0 : row_reg + 8'd1;
                        dcnt_reg  <= 8'd0;
                    end
                end
                S_DRAIN: dcnt_reg <= dcnt_reg + 8'd1;
                default: ;
            endcase
        end
    end

    // Row buffer: cleared at the first fetch cycle, column c written at fetch cycle c+1.
    for (genvar gi = 0; gi < GRID_COLS; gi++) begin : g_col
        logic [DATA_W-1:0] col_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                col_q <= '0;
            else if (is_fetch) begin
                if (col_reg == 8'd0)
                    col_q <= '0;
                else if (col_reg == 8'(gi + 1))
                    col_q <= bus.mem_rd_data;
            end
        end
        assign row_buf[gi*DATA_W +: DATA_W] = col_q;
        assign vx_vec[gi] = issue_x && (iw_reg > 8'(gi));
    end

    assign bus.mem_rd_en       = rd_en;
    assign bus.mem_addr        = addr;
    assign bus.valid_y         = vy;
    assign bus.valid_x_vec     = vx_vec;
    assign bus.busy            = busy_c;
    assign bus.done            = done_c;
    assign bus.row_weight_vals = (state_reg == S_K_ISSUE) ? row_buf : weight_reg;
    assign bus.tag_row         = (state_reg == S_K_ISSUE) ? row_reg[3:0] : tag_reg;
    assign bus.image_val_vec   = (state_reg == S_I_ISSUE) ? row_buf : image_reg;
endmodule

// File: tb/tb_pe_grid_sequencer.sv
// Directed bench for pe_grid_sequencer: a timeline model built from the pass rules
// is compared against the DUT every cycle, plus literal timing/data expectations.
module tb_pe_grid_sequencer;
    localparam int GC   = 14;
    localparam int GR   = 12;
    localparam int DW   = 16;
    localparam int VW   = GC * DW;
    localparam int MAXC = 256;

    logic clk;
    logic rst;

    pe_grid_sequencer_if #(.GRID_COLS(GC), .DATA_W(DW)) bus ();

    pe_grid_sequencer #(.GRID_COLS(GC), .GRID_ROWS(GR), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] rd_q;
    always @(posedge clk) if (bus.mem_rd_en) rd_q <= mem[bus.mem_addr[9:0]];
    assign bus.mem_rd_data = rd_q;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs; cycle 1 is the period right after the start edge.
    logic          e_busy [MAXC];
    logic          e_rd   [MAXC];
    logic [15:0]   e_addr [MAXC];
    logic          e_vy   [MAXC];
    logic [3:0]    e_tag  [MAXC];
    logic [VW-1:0] e_w    [MAXC];
    logic [GC-1:0] e_vx   [MAXC];
    logic [VW-1:0] e_img  [MAXC];
    logic          e_done [MAXC];
    logic          hold_sched [MAXC];
    logic          exp_err;
    int            model_len, m_first_vy, m_done;

    logic chk_on = 1'b0;
    int   cur_cyc;
    int   d_first_vy, d_first_vx, d_done, d_reads;
    logic [VW-1:0] d_first_w, d_first_img;
    logic [GC-1:0] d_first_vxv;

    function automatic logic [VW-1:0] row_vec(input int base, input int w);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < GC; c++)
            if (c < w) v[c*DW +: DW] = mem[(base + c) & 1023];
        return v;
    endfunction

    task automatic build_model(input int kb, input int ib, input int kw, input int kh,
                               input int iw, input int ih, input int dr);
        int t;
        logic bad;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_rd[i] = 0; e_addr[i] = '0; e_vy[i] = 0; e_tag[i] = '0;
            e_w[i] = '0; e_vx[i] = '0; e_img[i] = '0; e_done[i] = 0;
        end
        exp_err = 1'b0;
        m_first_vy = -1;
        m_done = -1;
        bad = (kw < 1) || (kw > GC) || (iw < 1) || (iw > GC) || (kh < 1) || (kh > GR) || (ih < 1);
`ifdef PE_SEQ_CFG_CHECK_EN
        if (bad) begin
            exp_err = 1'b1;
            model_len = 20;
        end
`else
        kw = (kw < 1) ? 1 : (kw > GC) ? GC : kw;
        iw = (iw < 1) ? 1 : (iw > GC) ? GC : iw;
        kh = (kh < 1) ? 1 : (kh > GR) ? GR : kh;
        ih = (ih < 1) ? 1 : ih;
        bad = 1'b0;
`endif
        if (!bad) begin
            t = 1;
            for (int p = 0; p < 2; p++) begin
                int w, h, b;
                w = (p == 0) ? kw : iw;
                h = (p == 0) ? kh : ih;
                b = (p == 0) ? kb : ib;
                for (int r = 0; r < h; r++) begin
                    for (int c = 0; c <= w; c++) begin
                        e_busy[t] = 1;
                        if (c < w) begin
                            e_rd[t] = 1;
                            e_addr[t] = 16'((b + r * w + c) & 16'hFFFF);
                        end
                        t++;
                    end
                    while (hold_sched[t]) begin
                        e_busy[t] = 1;
                        t++;
                    end
                    e_busy[t] = 1;
                    if (p == 0) begin
                        e_vy[t] = 1;
                        e_tag[t] = 4'(r);
                        e_w[t] = row_vec(b + r * w, w);
                        if (m_first_vy < 0) m_first_vy = t;
                    end else begin
                        for (int c = 0; c < w; c++) e_vx[t][c] = 1'b1;
                        e_img[t] = row_vec(b + r * w, w);
                    end
                    t++;
                end
            end
            for (int d = 0; d < dr; d++) begin
                e_busy[t] = 1;
                t++;
            end
            e_busy[t] = 1;
            e_done[t] = 1;
            m_done = t;
            model_len = t + 1;
        end
    endtask

    task automatic cmp_cycle(input int n);
        logic ok;
        ok = (bus.busy === e_busy[n]) && (bus.mem_rd_en === e_rd[n]) &&
             (!e_rd[n] || bus.mem_addr === e_addr[n]) &&
             (bus.valid_y === e_vy[n]) &&
             (!e_vy[n] || (bus.tag_row === e_tag[n] && bus.row_weight_vals === e_w[n])) &&
             (bus.valid_x_vec === e_vx[n]) &&
             (e_vx[n] == '0 || bus.image_val_vec === e_img[n]) &&
             (bus.done === e_done[n]) && (bus.err === exp_err);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cycle_check cyc=%0d got busy=%b rd=%b addr=%h vy=%b tag=%h vx=%h done=%b err=%b w=%h img=%h | want busy=%b rd=%b addr=%h vy=%b tag=%h vx=%h done=%b err=%b w=%h img=%h",
                     n, bus.busy, bus.mem_rd_en, bus.mem_addr, bus.valid_y, bus.tag_row,
                     bus.valid_x_vec, bus.done, bus.err, bus.row_weight_vals, bus.image_val_vec,
                     e_busy[n], e_rd[n], e_addr[n], e_vy[n], e_tag[n], e_vx[n], e_done[n],
                     exp_err, e_w[n], e_img[n]);
        end
        if (bus.valid_y === 1'b1 && d_first_vy < 0) begin
            d_first_vy = n;
            d_first_w  = bus.row_weight_vals;
        end
        if (bus.valid_x_vec !== '0 && d_first_vx < 0) begin
            d_first_vx  = n;
            d_first_img = bus.image_val_vec;
            d_first_vxv = bus.valid_x_vec;
        end
        if (bus.done === 1'b1) d_done = n;
        if (bus.mem_rd_en === 1'b1) d_reads++;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_on) cmp_cycle(cur_cyc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic clear_hold();
        for (int i = 0; i < MAXC; i++) hold_sched[i] = 1'b0;
    endtask

    task automatic run_pass(input int kb, input int ib, input int kw, input int kh,
                            input int iw, input int ih, input int dr,
                            input int stop_at, input int dup_at);
        int lim;
        build_model(kb, ib, kw, kh, iw, ih, dr);
        d_first_vy = -1; d_first_vx = -1; d_done = -1; d_reads = 0;
        d_first_w = '0; d_first_img = '0; d_first_vxv = '0;
        @(negedge clk);
        bus.kernel_base  = 16'(kb);
        bus.image_base   = 16'(ib);
        bus.kernel_w     = 8'(kw);
        bus.kernel_h     = 8'(kh);
        bus.img_w        = 8'(iw);
        bus.img_h        = 8'(ih);
        bus.drain_cycles = 8'(dr);
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk_on = 1'b1;
        lim = (stop_at > 0) ? stop_at : model_len;
        for (int n = 1; n <= lim; n++) begin
            cur_cyc   = n;
            bus.hold  = hold_sched[n];
            bus.start = (n == dup_at);
            @(posedge clk);
            #1;
        end
        chk_on = 1'b0;
        bus.hold = 1'b0;
        bus.start = 1'b0;
        $display("pass kw=%0d kh=%0d iw=%0d ih=%0d drain=%0d: first_vy=%0d first_vx=%0d done=%0d reads=%0d",
                 kw, kh, iw, ih, dr, d_first_vy, d_first_vx, d_done, d_reads);
    endtask

    initial begin
        logic [VW-1:0] lit_w, lit_img;
        logic quiet;
        for (int a = 0; a < 1024; a++)
            mem[a] = (a < 36) ? 16'd1 : (a < 72) ? 16'(a - 35) : 16'((a * 37 + 11) & 16'hFFFF);
        lit_w = '0;
        lit_img = '0;
        for (int c = 0; c < 6; c++) begin
            lit_w[c*DW +: DW]   = 16'd1;
            lit_img[c*DW +: DW] = 16'(c + 1);
        end
        clear_hold();
        bus.start = 0; bus.kernel_base = 0; bus.image_base = 0; bus.kernel_w = 0;
        bus.kernel_h = 0; bus.img_w = 0; bus.img_h = 0; bus.drain_cycles = 0; bus.hold = 0;
        rst = 1'b1;
        fork
            compare_loop();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 0 || bus.mem_rd_en !== 0 || bus.valid_y !== 0 || bus.valid_x_vec !== '0 ||
            bus.done !== 0 || bus.err !== 0 || bus.row_weight_vals !== '0 ||
            bus.image_val_vec !== '0 || bus.tag_row !== 0 || bus.mem_addr !== 0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rd=%b vy=%b vx=%h done=%b err=%b, expected all zero",
                     bus.busy, bus.mem_rd_en, bus.valid_y, bus.valid_x_vec, bus.done, bus.err);
        end
        rst = 1'b0;

        // 6x6 kernel / 6x6 image, drain 4, with an ignored start while busy.
        run_pass(0, 36, 6, 6, 6, 6, 4, 0, 30);
        check_int("model_first_vy", m_first_vy, 8);
        check_int("model_done", m_done, 101);
        check_int("first_valid_y", d_first_vy, 8);
        check_int("first_valid_x", d_first_vx, 56);
        check_int("done_cycle", d_done, 101);
        check_vec("first_weights", d_first_w, lit_w);
        check_vec("first_image_row", d_first_img, lit_img);
        check_int("first_valid_x_vec", int'(d_first_vxv), 'h3F);
        check_vec("weights_held", bus.row_weight_vals, lit_w);

        // Back-pressure during the first kernel issue.
        clear_hold();
        for (int i = 8; i <= 10; i++) hold_sched[i] = 1'b1;
        run_pass(0, 36, 6, 6, 6, 6, 4, 0, 0);
        clear_hold();
        check_int("hold_first_valid_y", d_first_vy, 11);
        check_int("hold_first_valid_x", d_first_vx, 59);
        check_int("hold_done_cycle", d_done, 104);

        // Reset in cycle 20 aborts; nothing happens until the next start.
        run_pass(0, 36, 6, 6, 6, 6, 4, 19, 0);
        rst = 1'b1;
        #2;
        checks++;
        if (bus.busy !== 0 || bus.mem_rd_en !== 0 || bus.valid_y !== 0 ||
            bus.row_weight_vals !== '0 || bus.tag_row !== 0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b rd=%b vy=%b tag=%0d w=%h, expected zero",
                     bus.busy, bus.mem_rd_en, bus.valid_y, bus.tag_row, bus.row_weight_vals);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.busy !== 0 || bus.valid_y !== 0 || bus.valid_x_vec !== '0 ||
                bus.mem_rd_en !== 0 || bus.done !== 0) quiet = 1'b0;
        end
        check_int("quiet_after_reset", int'(quiet), 1);
        run_pass(0, 36, 6, 6, 6, 6, 4, 0, 0);
        check_int("post_reset_done_cycle", d_done, 101);

        // Over-wide kernel and image.
        run_pass(100, 200, 15, 2, 15, 2, 2, 0, 0);
`ifdef PE_SEQ_CFG_CHECK_EN
        check_int("wide_err", int'(bus.err), 1);
        check_int("wide_reads", d_reads, 0);
`else
        check_int("wide_reads", d_reads, 56);
        check_int("wide_valid_x_vec", int'(d_first_vxv), 'h3FFF);
        check_int("wide_weight_col13", int'(d_first_w[13*DW +: DW]), 4192);
`endif

        // Minimal pass with no drain.
        run_pass(300, 301, 1, 1, 1, 1, 0, 0, 0);
        check_int("tiny_valid_y", d_first_vy, 3);
        check_int("tiny_valid_x", d_first_vx, 6);
        check_int("tiny_done", d_done, 7);
        check_int("tiny_err_cleared", int'(bus.err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
